decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Clocking and reset SHALL be one clock and a synchronous, active-high reset: CLOCK and RESET.
REQ-002 Ports SHALL be as follows, with CLOCK and RESET first:
- CLOCK  in  1  sole clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IfInstr  in  32  instruction from fetch.
- IfPC  in  32  PC+4 of IfInstr.
- IfValid  in  1  IfInstr is real; 0 = bubble.
- Flush  in  1  branch resolved taken in EX; kill younger instructions.
- ExMemRead  in  1  instruction now in EX is a load.
- ExDest  in  5  destination register of instruction in EX.
- WbWriteEnable  in  1  register-file write occurs this cycle.
- WbDest  in  5  register-file write address this cycle.
- RegRead1  out  5  register-file read address 1 (rs).
- RegRead2  out  5  register-file read address 2 (rt).
- Stall  out  1  hold fetch PC and IfInstr this cycle.
- IdValid  out  1  ID/EX slot holds a real instruction.
- IdOpcode, IdFunct  out  6 each  instr[31:26], instr[5:0].
- IdRs, IdRt, IdDest  out  5 each  source and destination register numbers.
- IdImm  out  32  extended immediate.
- IdPC  out  32  PC+4 of the instruction.
- IdRegWrite, IdMemRead, IdMemWrite  out  1 each  control bits.

Function
REQ-003 The block SHALL have two register stages: the IF/ID register (instr, pc, valid) and the ID/EX output register (all Id* outputs).
REQ-004 RegRead1 and RegRead2 SHALL be driven combinationally from IF/ID instr[25:21] and instr[20:16].
- Because the register file registers its reads on posedge, its ReadOut1/2 SHALL be cycle-aligned with the Id* outputs.
REQ-005 Latency SHALL be: instruction presented in cycle N (no stall) -> Id* valid in cycle N+2.
REQ-006 Decode SHALL be:
- opcode 0x00: IdDest=rd; IdRegWrite=1 unless funct=0x08 (jr).
- 0x23 lw: IdDest=rt; IdMemRead=1; IdRegWrite=1.
- 0x2B sw: IdMemWrite=1.
- 0x08/0x09/0x0A: IdDest=rt; IdRegWrite=1; immediate sign-extended.
- 0x0C/0x0D: IdDest=rt; IdRegWrite=1; immediate zero-extended.
- 0x04/0x05: no write; immediate sign-extended.
- Any other opcode: all control bits 0; IdValid follows the valid bit.
REQ-007 IdRegWrite SHALL be forced to 0 when IdDest=0.
REQ-008 Source use SHALL be: rs is used by every valid instruction; rt is used only by opcode 0x00, 0x2B, 0x04 and 0x05; register 0 is never a hazard.
REQ-009 Load-use hazard: when IF/ID is valid, ExMemRead=1, and ExDest (nonzero) equals a used source, Stall=1.
REQ-010 WB hazard: when IF/ID is valid, WbWriteEnable=1, and WbDest (nonzero) equals a used source, Stall=1, because the register file has no write-through.
REQ-011 On Stall=1 (Flush=0), IF/ID SHALL hold and the ID/EX register SHALL load a bubble (IdValid=0, all control bits 0, other fields 0).
REQ-012 Each hazard SHALL last exactly one cycle per triggering event; on the following cycle the condition is re-evaluated.
REQ-013 On Flush=1, IF/ID valid SHALL clear and the ID/EX register SHALL load a bubble.
- Flush overrides Stall; Stall SHALL read 0 in that cycle.
REQ-014 With no stall and no flush, IF/ID SHALL load IfInstr/IfPC/IfValid and the ID/EX register SHALL load the decoded IF/ID contents.
REQ-015 An invalid IF/ID entry SHALL never raise Stall and SHALL produce a bubble.

Reset
REQ-016 On RESET=1 at posedge, IF/ID and all ID/EX fields SHALL clear to 0, giving RegRead1/2=0, Stall=0 and IdValid=0.
REQ-017 RESET SHALL override Flush and Stall, and SHALL discard an in-flight or stalled instruction.
REQ-018 The first instruction presented in the cycle after reset release SHALL appear valid on Id* two cycles later.

Verification
REQ-019 Reset: hold RESET 2 cycles with IfValid=1 -> all outputs 0 and Stall=0 during and one cycle after reset.
REQ-020 Decode: present 0x2128FFFF (addi $8,$9,-1) with IfPC=0x04 -> two cycles later RegRead1=9 was issued, IdDest=8, IdImm=0xFFFFFFFF, IdRegWrite=1, IdPC=0x04.
REQ-021 Load-use: IF/ID holds 0x01095020 (add $10,$8,$9) with ExMemRead=1, ExDest=9 -> Stall=1 for one cycle, one bubble, then add issues with IdDest=10.
REQ-022 WB hazard: IF/ID holds 0xAD280000 (sw $8,0($9)) with WbWriteEnable=1, WbDest=8 -> Stall=1 for one cycle, then sw issues with IdMemWrite=1.
REQ-023 Flush priority: hazard and Flush both asserted -> Stall=0, IF/ID valid=0, IdValid=0 next cycle.
REQ-024 $0 and opcode coverage: ExMemRead=1, ExDest=0 with a reader of $0 -> no stall; opcode 0x3F -> IdValid=1 with all control bits 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/execute-facing signal bundle for decode_stage.
// The master side drives the fetch, EX and WB inputs; the slave side is the decode stage.
interface decode_stage_if;
    logic [31:0] IfInstr;
    logic [31:0] IfPC;
    logic        IfValid;
    logic        Flush;
    logic        ExMemRead;
    logic [4:0]  ExDest;
    logic        WbWriteEnable;
    logic [4:0]  WbDest;
    logic [4:0]  RegRead1;
    logic [4:0]  RegRead2;
    logic        Stall;
    logic        IdValid;
    logic [5:0]  IdOpcode;
    logic [5:0]  IdFunct;
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic [4:0]  IdDest;
    logic [31:0] IdImm;
    logic [31:0] IdPC;
    logic        IdRegWrite;
    logic        IdMemRead;
    logic        IdMemWrite;

    modport master (
        output IfInstr, IfPC, IfValid, Flush, ExMemRead, ExDest, WbWriteEnable, WbDest,
        input  RegRead1, RegRead2, Stall, IdValid, IdOpcode, IdFunct, IdRs, IdRt,
               IdDest, IdImm, IdPC, IdRegWrite, IdMemRead, IdMemWrite
    );

    modport slave (
        input  IfInstr, IfPC, IfValid, Flush, ExMemRead, ExDest, WbWriteEnable, WbDest,
        output RegRead1, RegRead2, Stall, IdValid, IdOpcode, IdFunct, IdRs, IdRt,
               IdDest, IdImm, IdPC, IdRegWrite, IdMemRead, IdMemWrite
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage: IF/ID register, field decode, load-use / WB hazard stall,
// and a registered ID/EX output slot.
module decode_stage (
    input  logic          CLOCK,
    input  logic          RESET,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_t;

    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    id_t         r_id;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dest;
    logic        w_writes;
    logic        w_zext;
    logic        w_uses_rt;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_ex_hit;
    logic        w_wb_hit;
    logic        w_stall;
    id_t         w_dec;

    assign w_op    = r_if_instr[31:26];
    assign w_rs    = r_if_instr[25:21];
    assign w_rt    = r_if_instr[20:16];
    assign w_rd    = r_if_instr[15:11];
    assign w_funct = r_if_instr[5:0];

    // Opcode classification: destination, write/memory controls, extension mode, rt usage.
    always_comb begin
        w_dest      = 5'd0;
        w_writes    = 1'b0;
        w_zext      = 1'b0;
        w_uses_rt   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        case (w_op)
            6'h00: begin
                w_dest    = w_rd;
                w_writes  = (w_funct != 6'h08);
                w_uses_rt = 1'b1;
            end
            6'h23: begin
                w_dest     = w_rt;
                w_writes   = 1'b1;
                w_mem_read = 1'b1;
            end
            6'h2B: begin
                w_mem_write = 1'b1;
                w_uses_rt   = 1'b1;
            end
            6'h08, 6'h09, 6'h0A: begin
                w_dest   = w_rt;
                w_writes = 1'b1;
            end
            6'h0C, 6'h0D: begin
                w_dest   = w_rt;
                w_writes = 1'b1;
                w_zext   = 1'b1;
            end
            6'h04, 6'h05: begin
                w_uses_rt = 1'b1;
            end
            default: begin
                w_dest = 5'd0;
            end
        endcase
    end

    // Full decoded record for the ID/EX slot; an invalid IF/ID entry decodes to a bubble.
    always_comb begin
        w_dec = '0;
        if (r_if_valid) begin
            w_dec.valid     = 1'b1;
            w_dec.opcode    = w_op;
            w_dec.funct     = w_funct;
            w_dec.rs        = w_rs;
            w_dec.rt        = w_rt;
            w_dec.dest      = w_dest;
            w_dec.imm       = w_zext ? {16'h0000, r_if_instr[15:0]}
                                     : {{16{r_if_instr[15]}}, r_if_instr[15:0]};
            w_dec.pc        = r_if_pc;
            w_dec.reg_write = w_writes && (w_dest != 5'd0);
            w_dec.mem_read  = w_mem_read;
            w_dec.mem_write = w_mem_write;
        end else begin
            w_dec = '0;
        end
    end

    // The register file has no write-through, so a same-cycle WB write is a hazard too.
    assign w_ex_hit = bus.ExMemRead && (bus.ExDest != 5'd0) &&
                      ((bus.ExDest == w_rs) || (w_uses_rt && (bus.ExDest == w_rt)));
    assign w_wb_hit = bus.WbWriteEnable && (bus.WbDest != 5'd0) &&
                      ((bus.WbDest == w_rs) || (w_uses_rt && (bus.WbDest == w_rt)));
    assign w_stall  = r_if_valid && (w_ex_hit || w_wb_hit) && !bus.Flush && !RESET;

    // Pipeline registers: reset beats flush, flush beats stall.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_if_instr <= 32'd0;
            r_if_pc    <= 32'd0;
            r_if_valid <= 1'b0;
            r_id       <= '0;
        end else if (bus.Flush) begin
            r_if_valid <= 1'b0;
            r_id       <= '0;
        end else if (w_stall) begin
            r_id       <= '0;
        end else begin
            r_if_instr <= bus.IfInstr;
            r_if_pc    <= bus.IfPC;
            r_if_valid <= bus.IfValid;
            r_id       <= w_dec;
        end
    end

    assign bus.RegRead1   = w_rs;
    assign bus.RegRead2   = w_rt;
    assign bus.Stall      = w_stall;
    assign bus.IdValid    = r_id.valid;
    assign bus.IdOpcode   = r_id.opcode;
    assign bus.IdFunct    = r_id.funct;
    assign bus.IdRs       = r_id.rs;
    assign bus.IdRt       = r_id.rt;
    assign bus.IdDest     = r_id.dest;
    assign bus.IdImm      = r_id.imm;
    assign bus.IdPC       = r_id.pc;
    assign bus.IdRegWrite = r_id.reg_write;
    assign bus.IdMemRead  = r_id.mem_read;
    assign bus.IdMemWrite = r_id.mem_write;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, hand-built hazard/flush/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_decode_stage;
    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
    } id_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
    } vec_t;

    logic CLOCK;
    logic RESET;
    int   checks;
    int   errors;

    decode_stage_if ifc ();

    decode_stage dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (ifc.slave)
    );

    id_t dut_id;
    assign dut_id = {ifc.IdValid, ifc.IdOpcode, ifc.IdFunct, ifc.IdRs, ifc.IdRt, ifc.IdDest,
                     ifc.IdImm, ifc.IdPC, ifc.IdRegWrite, ifc.IdMemRead, ifc.IdMemWrite};

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
        ifc.IfInstr = instr;
        ifc.IfPC    = pc;
        ifc.IfValid = valid;
    endtask

    task automatic haz(input logic exmr, input logic [4:0] exd, input logic wbwe,
                       input logic [4:0] wbd, input logic flush);
        ifc.ExMemRead     = exmr;
        ifc.ExDest        = exd;
        ifc.WbWriteEnable = wbwe;
        ifc.WbDest        = wbd;
        ifc.Flush         = flush;
    endtask

    // Reference decode written directly from the instruction-set rules.
    function automatic id_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        id_t d;
        logic [5:0] op;
        logic writes_rt;
        op        = instr[31:26];
        writes_rt = op inside {6'h23, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
        d         = '0;
        d.valid   = 1'b1;
        d.opcode  = op;
        d.funct   = instr[5:0];
        d.rs      = instr[25:21];
        d.rt      = instr[20:16];
        d.pc      = pc;
        d.imm     = (op inside {6'h0C, 6'h0D}) ? 32'(instr[15:0])
                                               : 32'($signed(instr[15:0]));
        d.dest    = (op == 6'h00) ? instr[15:11] : (writes_rt ? instr[20:16] : 5'd0);
        d.rw      = ((op == 6'h00) ? (instr[5:0] != 6'h08) : writes_rt) && (d.dest != 5'd0);
        d.mr      = (op == 6'h23);
        d.mw      = (op == 6'h2B);
        return d;
    endfunction

    function automatic logic ref_hazard(input logic [31:0] instr, input logic exmr,
                                        input logic [4:0] exd, input logic wbwe,
                                        input logic [4:0] wbd);
        logic [4:0] srcs[$];
        logic hit;
        srcs.push_back(instr[25:21]);
        if (instr[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05}) srcs.push_back(instr[20:16]);
        hit = 1'b0;
        foreach (srcs[k]) begin
            if (srcs[k] != 5'd0 && ((exmr && srcs[k] == exd) || (wbwe && srcs[k] == wbd)))
                hit = 1'b1;
        end
        return hit;
    endfunction

    vec_t       vecs[11];
    logic [5:0] ops[12];
    id_t        exp_id;
    logic [31:0] w_instr;
    logic       m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    id_t        m_id;
    logic       exp_stall;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{32'h2128FFFF, 5'd8,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h01095020, 5'd10, 32'h00005020, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h03E00008, 5'd0,  32'h00000008, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h8D2A0004, 5'd10, 32'h00000004, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'hAD280000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h3528F000, 5'd8,  32'h0000F000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h1128FFFE, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hFC000000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h20000005, 5'd0,  32'h00000005, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h3128ABCD, 5'd8,  32'h0000ABCD, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h292AFFF0, 5'd10, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0};
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h3F, 6'h02};

        // Reset held two cycles with a valid instruction present.
        RESET = 1'b1;
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(32'h2128FFFF, 32'h00000004, 1'b1);
        tick();
        chk("reset_c1_id", dut_id, 95'd0);
        chk("reset_c1_rr_stall", {ifc.RegRead1, ifc.RegRead2, ifc.Stall}, 11'd0);
        tick();
        chk("reset_c2_id", dut_id, 95'd0);
        chk("reset_c2_rr_stall", {ifc.RegRead1, ifc.RegRead2, ifc.Stall}, 11'd0);
        RESET = 1'b0;
        tick();
        chk("post_reset_idvalid", ifc.IdValid, 1'b0);
        chk("post_reset_stall", ifc.Stall, 1'b0);
        chk("addi_regread1", ifc.RegRead1, 5'd9);
        drive(32'h0, 32'h0, 1'b0);
        tick();
        chk("addi_first_after_reset", dut_id,
            {1'b1, 6'h08, 6'h3F, 5'd9, 5'd8, 5'd8, 32'hFFFFFFFF, 32'h00000004, 1'b1, 1'b0, 1'b0});

        // Decode vector table.
        for (int i = 0; i < 11; i++) begin
            w_instr = vecs[i].instr;
            drive(w_instr, 32'(i * 4 + 4), 1'b1);
            tick();
            chk($sformatf("vec%0d_regread", i), {ifc.RegRead1, ifc.RegRead2},
                {w_instr[25:21], w_instr[20:16]});
            drive(32'h0, 32'h0, 1'b0);
            tick();
            exp_id = {1'b1, w_instr[31:26], w_instr[5:0], w_instr[25:21], w_instr[20:16],
                      vecs[i].dest, vecs[i].imm, 32'(i * 4 + 4), vecs[i].rw, vecs[i].mr,
                      vecs[i].mw};
            chk($sformatf("vec%0d_decode", i), dut_id, exp_id);
        end

        // Load-use: add $10,$8,$9 behind a load into $9.
        drive(32'h01095020, 32'h00000100, 1'b1);
        tick();
        haz(1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        drive(32'h8D2A0004, 32'h00000104, 1'b1);
        #1;
        chk("loaduse_stall", ifc.Stall, 1'b1);
        tick();
        chk("loaduse_bubble", dut_id, 95'd0);
        chk("loaduse_ifid_held", ifc.RegRead1, 5'd8);
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("loaduse_stall_clear", ifc.Stall, 1'b0);
        tick();
        chk("loaduse_add_issue", dut_id,
            {1'b1, 6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 32'h00005020, 32'h00000100, 1'b1, 1'b0, 1'b0});
        drive(32'h0, 32'h0, 1'b0);
        tick();
        chk("loaduse_next_lw", dut_id,
            {1'b1, 6'h23, 6'h04, 5'd9, 5'd10, 5'd10, 32'h00000004, 32'h00000104, 1'b1, 1'b1, 1'b0});

        // WB hazard: sw $8,0($9) while $8 is being written.
        drive(32'hAD280000, 32'h00000200, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0);
        haz(1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        #1;
        chk("wb_stall", ifc.Stall, 1'b1);
        tick();
        chk("wb_bubble", dut_id, 95'd0);
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk("wb_sw_issue", dut_id,
            {1'b1, 6'h2B, 6'h00, 5'd9, 5'd8, 5'd0, 32'h00000000, 32'h00000200, 1'b0, 1'b0, 1'b1});

        // Flush beats a simultaneous hazard.
        drive(32'h01095020, 32'h00000300, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0);
        haz(1'b1, 5'd9, 1'b0, 5'd0, 1'b1);
        #1;
        chk("flush_stall_low", ifc.Stall, 1'b0);
        tick();
        chk("flush_idvalid", ifc.IdValid, 1'b0);
        haz(1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        chk("flush_ifid_invalid_nostall", ifc.Stall, 1'b0);
        tick();
        chk("flush_no_issue", ifc.IdValid, 1'b0);

        // Register $0 never hazards.
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(32'h00002020, 32'h00000400, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0);
        haz(1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        chk("zero_reg_nostall", ifc.Stall, 1'b0);
        tick();
        chk("zero_reg_issue", dut_id,
            {1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd4, 32'h00002020, 32'h00000400, 1'b1, 1'b0, 1'b0});

        // Reset discards a stalled instruction.
        drive(32'h01095020, 32'h00000500, 1'b1);
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        haz(1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        RESET = 1'b1;
        #1;
        chk("reset_over_stall", ifc.Stall, 1'b0);
        tick();
        chk("reset_discard_id", dut_id, 95'd0);
        RESET = 1'b0;
        haz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(32'h0, 32'h0, 1'b0);
        tick();
        chk("reset_discard_gone", ifc.IdValid, 1'b0);

        // Randomized traffic vs. transaction-level model; start from a known reset.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pc    = 32'd0;
        m_id    = '0;
        for (int n = 0; n < 3000; n++) begin
            w_instr        = $urandom;
            w_instr[31:26] = ops[$urandom_range(0, 11)];
            w_instr[25:21] = 5'($urandom_range(0, 7));
            w_instr[20:16] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) w_instr[5:0] = 6'h08;
            RESET = ($urandom_range(0, 49) == 0);
            drive(w_instr, $urandom, ($urandom_range(0, 3) != 0));
            haz(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0));
            #1;
            exp_stall = !RESET && !ifc.Flush && m_valid &&
                        ref_hazard(m_instr, ifc.ExMemRead, ifc.ExDest, ifc.WbWriteEnable, ifc.WbDest);
            chk("rand_stall", ifc.Stall, exp_stall);
            if (m_valid) chk("rand_regread", {ifc.RegRead1, ifc.RegRead2},
                             {m_instr[25:21], m_instr[20:16]});
            if (RESET) begin
                m_valid = 1'b0;
                m_instr = 32'd0;
                m_pc    = 32'd0;
                m_id    = '0;
            end else if (ifc.Flush) begin
                m_valid = 1'b0;
                m_id    = '0;
            end else if (exp_stall) begin
                m_id = '0;
            end else begin
                m_id    = m_valid ? ref_decode(m_instr, m_pc) : id_t'(0);
                m_instr = ifc.IfInstr;
                m_pc    = ifc.IfPC;
                m_valid = ifc.IfValid;
            end
            tick();
            chk("rand_id", dut_id, m_id);
        end
        RESET = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
